// File: rtl/insfetch_if.sv
`default_nettype none
// insfetch_if: fetch-stage bus joining the icache, decoder and RoB ports of insfetch.
// Revision: 1.0
interface insfetch_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_instr;
  logic        if_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        isjump;
  logic        stall;
  logic        dc_valid;
  logic [31:0] dc_nextpc;
  logic        rob_clear;
  logic [31:0] rob_new_pc;
  logic        br_update;
  logic [31:0] br_pc;
  logic        br_taken;

  modport master (
    output ic_req, ic_addr, if_valid, instr, pc, isjump,
    input  ic_ready, ic_instr, stall, dc_valid, dc_nextpc,
           rob_clear, rob_new_pc, br_update, br_pc, br_taken
  );

  modport slave (
    input  ic_req, ic_addr, if_valid, instr, pc, isjump,
    output ic_ready, ic_instr, stall, dc_valid, dc_nextpc,
           rob_clear, rob_new_pc, br_update, br_pc, br_taken
  );
endinterface
`default_nettype wire

// File: rtl/insfetch.sv
`default_nettype none
// insfetch: instruction fetch stage with a 2-bit-counter BHT feeding isjump.
// Revision: 1.0
module insfetch #(
  parameter int          BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  insfetch_if.master bus
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam int BHT_ENTRIES = 1 << BHT_BITS;

  logic [1:0]          state;
  logic [31:0]         fetch_pc;
  logic [31:0]         instr_q;
  logic [31:0]         pc_q;
  logic                valid_q;
  logic                isjump_q;
  logic [1:0]          bht [BHT_ENTRIES];
  logic [BHT_BITS-1:0] rd_idx;
  logic [BHT_BITS-1:0] wr_idx;
  logic [1:0]          wr_old;
  logic [1:0]          wr_new;
  logic                is_branch;
  logic                unused_inputs;

  assign bus.ic_req   = (state == FETCH);
  assign bus.ic_addr  = fetch_pc;
  assign bus.if_valid = valid_q;
  assign bus.instr    = instr_q;
  assign bus.pc       = pc_q;
  assign bus.isjump   = isjump_q;

  // stall is advisory; acceptance is signalled solely by dc_valid
  assign unused_inputs = &{1'b0, bus.stall, bus.br_pc[31:BHT_BITS+2], bus.br_pc[1:0]};

  assign rd_idx    = fetch_pc[BHT_BITS+1:2];
  assign wr_idx    = bus.br_pc[BHT_BITS+1:2];
  assign wr_old    = bht[wr_idx];
  assign is_branch = (bus.ic_instr[6:0] == 7'b1100011);

  always_comb begin
    wr_new = wr_old;
    if (bus.br_taken) begin
      if (wr_old != 2'b11) wr_new = wr_old + 2'd1;
    end else begin
      if (wr_old != 2'b00) wr_new = wr_old - 2'd1;
    end
  end

  // Training is independent of the FSM, so it still lands during a flush
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (rdy_in && bus.br_update) begin
      bht[wr_idx] <= wr_new;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      pc_q     <= 32'h0;
      isjump_q <= 1'b0;
    end else if (rdy_in) begin
      if (bus.rob_clear) begin
        fetch_pc <= bus.rob_new_pc;
        valid_q  <= 1'b0;
        state    <= FLUSH;
      end else begin
        case (state)
          FETCH: begin
            if (bus.ic_ready) begin
              instr_q  <= bus.ic_instr;
              pc_q     <= fetch_pc;
              isjump_q <= is_branch & bht[rd_idx][1];
              valid_q  <= 1'b1;
              state    <= HOLD;
            end
          end
          HOLD: begin
            if (bus.dc_valid) begin
              fetch_pc <= bus.dc_nextpc;
              valid_q  <= 1'b0;
              state    <= FETCH;
            end
          end
          FLUSH:   state <= FETCH;
          default: state <= FETCH;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_insfetch.sv
`default_nettype none
// tb_insfetch: directed stimulus for insfetch; a scoreboard checks every presented instruction.
// Revision: 1.0
module tb_insfetch;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] BEQ  = 32'h00000063;
  localparam logic [31:0] JAL  = 32'h0000006f;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        isjump;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic prev_valid = 1'b0;

  insfetch_if bus();

  insfetch #(.BHT_BITS(6), .RESET_PC(32'h0)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each new presentation pops one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (bus.if_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h instr %h, expected none", bus.pc, bus.instr);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", bus.instr, e.instr);
        chk("sb_pc", bus.pc, e.pc);
        chk("sb_isjump", {31'b0, bus.isjump}, {31'b0, e.isjump});
      end
    end
    prev_valid = bus.if_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.ic_req && n < 20) begin
      tick();
      n++;
    end
    if (!bus.ic_req) begin
      checks++;
      errors++;
      $display("FAIL wait_req: ic_req got %b expected 1 within %0d cycles", bus.ic_req, n);
    end
  endtask

  task automatic present(input logic [31:0] word, input logic [31:0] addr,
                         input logic jmp, input logic upd);
    wait_req();
    chk("ic_addr", bus.ic_addr, addr);
    tick();
    exp_q.push_back(exp_t'{instr: word, pc: addr, isjump: jmp});
    bus.ic_ready = 1'b1;
    bus.ic_instr = word;
    if (upd) begin
      bus.br_update = 1'b1;
      bus.br_pc     = addr;
      bus.br_taken  = 1'b0;
    end
    tick();
    bus.ic_ready  = 1'b0;
    bus.ic_instr  = 32'h0;
    bus.br_update = 1'b0;
    chk("if_valid_set", {31'b0, bus.if_valid}, 32'd1);
    chk("ic_req_in_hold", {31'b0, bus.ic_req}, 32'd0);
  endtask

  task automatic accept(input logic [31:0] next);
    bus.dc_valid  = 1'b1;
    bus.dc_nextpc = next;
    tick();
    bus.dc_valid = 1'b0;
    chk("if_valid_clr", {31'b0, bus.if_valid}, 32'd0);
    chk("ic_req_after_acc", {31'b0, bus.ic_req}, 32'd1);
    chk("ic_addr_next", bus.ic_addr, next);
  endtask

  task automatic fetch(input logic [31:0] word, input logic [31:0] addr, input logic jmp,
                       input logic [31:0] next, input logic upd);
    present(word, addr, jmp, upd);
    accept(next);
  endtask

  task automatic train(input logic [31:0] addr, input logic taken, input int n);
    bus.br_update = 1'b1;
    bus.br_pc     = addr;
    bus.br_taken  = taken;
    repeat (n) tick();
    bus.br_update = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ic_ready   = 1'b0;
    bus.ic_instr   = 32'h0;
    bus.stall      = 1'b0;
    bus.dc_valid   = 1'b0;
    bus.dc_nextpc  = 32'h0;
    bus.rob_clear  = 1'b0;
    bus.rob_new_pc = 32'h0;
    bus.br_update  = 1'b0;
    bus.br_pc      = 32'h0;
    bus.br_taken   = 1'b0;

    repeat (2) tick();
    chk("rst_ic_req", {31'b0, bus.ic_req}, 32'd1);
    chk("rst_ic_addr", bus.ic_addr, 32'h0);
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_isjump", {31'b0, bus.isjump}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++)
      fetch(ADDI + 32'(k << 7), 32'(4 * k), 1'b0, 32'(4 * k + 4), 1'b0);

    present(ADDI, 32'h10, 1'b0, 1'b0);
    bus.stall = 1'b1;
    repeat (5) begin
      tick();
      chk("stall_instr", bus.instr, ADDI);
      chk("stall_pc", bus.pc, 32'h10);
      chk("stall_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("stall_ic_req", {31'b0, bus.ic_req}, 32'd0);
    end
    bus.stall = 1'b0;
    accept(32'h40);

    // Counter at 0x40 walks 01 -> 11 -> 00 and is probed at each boundary
    train(32'h40, 1'b1, 2);
    fetch(BEQ, 32'h40, 1'b1, 32'h40, 1'b0);
    train(32'h40, 1'b0, 3);
    fetch(BEQ, 32'h40, 1'b0, 32'h40, 1'b0);
    train(32'h40, 1'b0, 2);
    train(32'h40, 1'b1, 1);
    fetch(BEQ, 32'h40, 1'b0, 32'h40, 1'b0);
    train(32'h40, 1'b1, 1);
    fetch(BEQ, 32'h40, 1'b1, 32'h40, 1'b0);
    train(32'h40, 1'b1, 3);
    train(32'h40, 1'b0, 1);
    fetch(BEQ, 32'h40, 1'b1, 32'h40, 1'b0);
    fetch(BEQ, 32'h40, 1'b1, 32'h40, 1'b1);
    fetch(BEQ, 32'h40, 1'b0, 32'h40, 1'b0);
    train(32'h40, 1'b1, 2);
    fetch(JAL, 32'h40, 1'b0, 32'h40, 1'b0);
    fetch(BEQ, 32'h40, 1'b1, 32'h80, 1'b0);

    present(ADDI, 32'h80, 1'b0, 1'b0);
    bus.rob_clear  = 1'b1;
    bus.rob_new_pc = 32'h100;
    bus.dc_valid   = 1'b1;
    bus.dc_nextpc  = 32'h200;
    bus.br_update  = 1'b1;
    bus.br_pc      = 32'h44;
    bus.br_taken   = 1'b1;
    tick();
    bus.rob_clear = 1'b0;
    bus.dc_valid  = 1'b0;
    bus.br_update = 1'b0;
    chk("flush_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("flush_ic_req", {31'b0, bus.ic_req}, 32'd0);
    tick();
    chk("flush_ic_req_after", {31'b0, bus.ic_req}, 32'd1);
    chk("flush_ic_addr", bus.ic_addr, 32'h100);

    bus.ic_ready   = 1'b1;
    bus.ic_instr   = BEQ;
    bus.rob_clear  = 1'b1;
    bus.rob_new_pc = 32'h44;
    tick();
    bus.ic_ready  = 1'b0;
    bus.rob_clear = 1'b0;
    chk("flush2_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("flush2_ic_req", {31'b0, bus.ic_req}, 32'd0);
    tick();
    chk("flush2_ic_addr", bus.ic_addr, 32'h44);
    fetch(BEQ, 32'h44, 1'b1, 32'h48, 1'b0);

    present(ADDI, 32'h48, 1'b0, 1'b0);
    rdy           = 1'b0;
    bus.dc_valid  = 1'b1;
    bus.dc_nextpc = 32'h300;
    bus.br_update = 1'b1;
    bus.br_pc     = 32'h48;
    bus.br_taken  = 1'b1;
    repeat (3) begin
      tick();
      chk("rdy_pc", bus.pc, 32'h48);
      chk("rdy_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("rdy_ic_req", {31'b0, bus.ic_req}, 32'd0);
    end
    bus.dc_valid  = 1'b0;
    bus.br_update = 1'b0;
    rdy           = 1'b1;
    accept(32'h48);
    fetch(BEQ, 32'h48, 1'b0, 32'h44, 1'b0);
    fetch(BEQ, 32'h44, 1'b1, 32'h4c, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ic_req", {31'b0, bus.ic_req}, 32'd1);
    chk("arst_ic_addr", bus.ic_addr, 32'h0);
    chk("arst_instr", bus.instr, 32'h0);
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("arst_isjump", {31'b0, bus.isjump}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    fetch(ADDI, 32'h0, 1'b0, 32'h40, 1'b0);
    fetch(BEQ, 32'h40, 1'b0, 32'h44, 1'b0);
    fetch(BEQ, 32'h44, 1'b0, 32'h48, 1'b0);

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
